// File: rtl/wght_acc_batch.sv
// Batched weight-gradient accumulator: two-stage pipeline forming d*x per lane, averaging over
// 2^BATCH_LOG2 samples. Define WGHT_ACC_SAT_EN to saturate instead of wrap on overflow.
module wght_acc_batch #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned FRAC       = 24,
    parameter int unsigned LANES      = 4,
    parameter int unsigned BATCH_LOG2 = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       i_d,
    input  logic [LANES*WIDTH-1:0] i_x,
    input  logic                   i_valid,
    input  logic                   i_clr,
    output logic [LANES*WIDTH-1:0] o,
    output logic                   o_valid,
    output logic [BATCH_LOG2-1:0]  o_cnt
);

    localparam int unsigned PW     = 2 * WIDTH;
    localparam int unsigned SEL_HI = WIDTH + FRAC - 1;

`ifdef WGHT_ACC_SAT_EN
    localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    logic signed [WIDTH:0]   sum_ext [LANES];
`endif

    logic signed [PW-1:0]    d_ext;
    logic signed [PW-1:0]    full    [LANES];
    logic signed [WIDTH-1:0] prod_d  [LANES];
    logic signed [WIDTH-1:0] prod_q  [LANES];
    logic signed [WIDTH-1:0] acc_q   [LANES];
    logic signed [WIDTH-1:0] acc_sum [LANES];

    logic                   s1_valid_q;
    logic [BATCH_LOG2-1:0]  cnt_q;
    logic [LANES*WIDTH-1:0] o_q;
    logic [LANES*WIDTH-1:0] mean;
    logic                   o_valid_q;
    logic                   batch_done;

    always_comb begin
        d_ext = {{WIDTH{i_d[WIDTH-1]}}, i_d};
        mean  = '0;
        for (int n = 0; n < LANES; n++) begin
            full[n] = d_ext * $signed({{WIDTH{i_x[n*WIDTH+WIDTH-1]}}, i_x[n*WIDTH +: WIDTH]});
`ifdef WGHT_ACC_SAT_EN
            // Selection overflows unless every bit above the kept field matches its sign bit.
            if ((&full[n][PW-1:SEL_HI]) || !(|full[n][PW-1:SEL_HI])) begin
                prod_d[n] = full[n][SEL_HI:FRAC];
            end else begin
                prod_d[n] = full[n][PW-1] ? SAT_MIN : SAT_MAX;
            end
            sum_ext[n] = {acc_q[n][WIDTH-1], acc_q[n]} + {prod_q[n][WIDTH-1], prod_q[n]};
            if (sum_ext[n][WIDTH] != sum_ext[n][WIDTH-1]) begin
                acc_sum[n] = sum_ext[n][WIDTH] ? SAT_MIN : SAT_MAX;
            end else begin
                acc_sum[n] = sum_ext[n][WIDTH-1:0];
            end
`else
            prod_d[n]  = full[n][SEL_HI:FRAC];
            acc_sum[n] = acc_q[n] + prod_q[n];
`endif
            mean[n*WIDTH +: WIDTH] = acc_sum[n] >>> BATCH_LOG2;
        end
    end

    assign batch_done = s1_valid_q & (&cnt_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            cnt_q      <= '0;
            o_q        <= '0;
            o_valid_q  <= 1'b0;
            for (int n = 0; n < LANES; n++) begin
                prod_q[n] <= '0;
                acc_q[n]  <= '0;
            end
        end else begin
            o_valid_q <= 1'b0;
            if (i_clr) begin
                s1_valid_q <= 1'b0;
                cnt_q      <= '0;
                for (int n = 0; n < LANES; n++) begin
                    acc_q[n] <= '0;
                end
            end else begin
                s1_valid_q <= i_valid;
                if (i_valid) begin
                    for (int n = 0; n < LANES; n++) begin
                        prod_q[n] <= prod_d[n];
                    end
                end
                if (batch_done) begin
                    // Last product of the batch: publish the mean and restart from zero.
                    o_q       <= mean;
                    o_valid_q <= 1'b1;
                    cnt_q     <= '0;
                    for (int n = 0; n < LANES; n++) begin
                        acc_q[n] <= '0;
                    end
                end else if (s1_valid_q) begin
                    cnt_q <= cnt_q + BATCH_LOG2'(1);
                    for (int n = 0; n < LANES; n++) begin
                        acc_q[n] <= acc_sum[n];
                    end
                end
            end
        end
    end

    assign o       = o_q;
    assign o_valid = o_valid_q;
    assign o_cnt   = cnt_q;

endmodule

// File: tb/tb_wght_acc_batch.sv
// Directed bench for wght_acc_batch at default parameters; expected values hand-computed in Q8.24.
module tb_wght_acc_batch;

    localparam logic [31:0] ONE   = 32'h0100_0000;
    localparam logic [31:0] HALF  = 32'h0080_0000;
    localparam logic [31:0] TWO   = 32'h0200_0000;
    localparam logic [31:0] THREE = 32'h0300_0000;
    localparam logic [31:0] BIG   = 32'h7FFF_FFFF;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  i_d = '0;
    logic [127:0] i_x = '0;
    logic         i_valid = 1'b0;
    logic         i_clr = 1'b0;
    logic [127:0] o;
    logic         o_valid;
    logic [2:0]   o_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n0;
    int pulse_cyc[$];
    logic [127:0] pulse_o[$];
    logic [127:0] exp_big;

    wght_acc_batch dut (
        .clk     (clk),
        .rst     (rst),
        .i_d     (i_d),
        .i_x     (i_x),
        .i_valid (i_valid),
        .i_clr   (i_clr),
        .o       (o),
        .o_valid (o_valid),
        .o_cnt   (o_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (o_valid === 1'b1) begin
            pulse_cyc.push_back(cyc);
            pulse_o.push_back(o);
        end
    endtask

    task automatic drive(input logic v, input logic c, input logic [31:0] d,
                         input logic [127:0] x);
        i_valid = v;
        i_clr   = c;
        i_d     = d;
        i_x     = x;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_o", o, '0);
        check("rst_valid", {127'd0, o_valid}, '0);
        check("rst_cnt", {125'd0, o_cnt}, '0);
        rst = 1'b1;
        tick();

        // 8 back-to-back samples d=1.0, x=0.5
        n0 = pulse_cyc.size();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, ONE, {4{HALF}});
            tick();
            if (i == 7) begin
                check("a_early_valid", {127'd0, o_valid}, '0);
                check("a_cnt7", {125'd0, o_cnt}, 128'd7);
            end
        end
        drive(1'b0, 1'b0, '0, '0);
        tick();
        check("a_valid", {127'd0, o_valid}, 128'd1);
        check("a_o", o, {4{HALF}});
        check("a_cnt0", {125'd0, o_cnt}, '0);
        tick();
        check("a_pulse_end", {127'd0, o_valid}, '0);
        check("a_hold", o, {4{HALF}});
        check("a_npulse", 128'(pulse_cyc.size() - n0), 128'd1);

        // d=2.0, lanes 1.0,-1.0,0.25,0 with idle gaps
        n0 = pulse_cyc.size();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, TWO, {32'h0, 32'h0040_0000, 32'hFF00_0000, ONE});
            tick();
            drive(1'b0, 1'b0, '0, '0);
            tick();
        end
        check("b_npulse", 128'(pulse_cyc.size() - n0), 128'd1);
        check("b_when", 128'(pulse_cyc[$]), 128'(cyc));
        check("b_o", pulse_o[$], {32'h0, 32'h0080_0000, 32'hFE00_0000, TWO});

        // 5 samples, clear with the 6th, then a clean batch
        n0 = pulse_cyc.size();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, ONE, {4{THREE}});
            tick();
        end
        check("c_cnt4", {125'd0, o_cnt}, 128'd4);
        drive(1'b1, 1'b1, ONE, {4{THREE}});
        tick();
        check("c_clr_cnt", {125'd0, o_cnt}, '0);
        drive(1'b0, 1'b0, '0, '0);
        tick();
        check("c_drop_cnt", {125'd0, o_cnt}, '0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, ONE, {4{ONE}});
            tick();
        end
        check("c_no_early", 128'(pulse_cyc.size() - n0), '0);
        drive(1'b0, 1'b0, '0, '0);
        tick();
        check("c_valid", {127'd0, o_valid}, 128'd1);
        check("c_o", o, {4{ONE}});

        // 16 consecutive samples: two pulses 8 cycles apart
        n0 = pulse_cyc.size();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, ONE, {4{ONE}});
            tick();
        end
        drive(1'b0, 1'b0, '0, '0);
        tick();
        tick();
        check("d_npulse", 128'(pulse_cyc.size() - n0), 128'd2);
        check("d_spacing", 128'(pulse_cyc[n0+1] - pulse_cyc[n0]), 128'd8);
        check("d_second_when", 128'(pulse_cyc[n0+1]), 128'(cyc - 1));
        check("d_o1", pulse_o[n0], {4{ONE}});
        check("d_o2", pulse_o[n0+1], {4{ONE}});

        // Overflow: d=x=max positive
`ifdef WGHT_ACC_SAT_EN
        exp_big = {4{32'h0FFF_FFFF}};
`else
        exp_big = {4{32'hFFFF_FF00}};
`endif
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, BIG, {4{BIG}});
            tick();
        end
        drive(1'b0, 1'b0, '0, '0);
        tick();
        check("e_valid", {127'd0, o_valid}, 128'd1);
        check("e_o", o, exp_big);

        // Asynchronous reset after 3 samples of a batch
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, ONE, {4{THREE}});
            tick();
        end
        drive(1'b0, 1'b0, '0, '0);
        #2;
        rst = 1'b0;
        #1;
        check("f_rst_o", o, '0);
        check("f_rst_valid", {127'd0, o_valid}, '0);
        check("f_rst_cnt", {125'd0, o_cnt}, '0);
        #2;
        rst = 1'b1;
        tick();
        check("f_cnt_after", {125'd0, o_cnt}, '0);
        n0 = pulse_cyc.size();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, ONE, {4{ONE}});
            tick();
        end
        check("f_no_early", 128'(pulse_cyc.size() - n0), '0);
        drive(1'b0, 1'b0, '0, '0);
        tick();
        check("f_valid", {127'd0, o_valid}, 128'd1);
        check("f_o", o, {4{ONE}});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wght_acc_batch.md
WGHT_ACC_BATCH -- requirements
Module: wght_acc_batch

Interface
REQ-001 SHALL have parameter WIDTH, default 32: fixed-point word width.
REQ-002 SHALL have parameter FRAC, default 24: fractional bits.
REQ-003 SHALL have parameter LANES, default 4: parallel weight channels sharing one delta.
REQ-004 SHALL have parameter BATCH_LOG2, default 3: batch size is 2^BATCH_LOG2 samples.
REQ-005 SHALL have port clk, input, 1: single clock, all state rising-edge.
REQ-006 SHALL have port rst, input, 1: asynchronous active-low reset; state cleared while rst=0.
REQ-007 SHALL have port i_d, input, WIDTH: signed delta, shared by all lanes.
REQ-008 SHALL have port i_x, input, LANES*WIDTH: signed inputs, lane n at bits [n*WIDTH +: WIDTH].
REQ-009 SHALL have port i_valid, input, 1: i_d/i_x carry a sample this cycle.
REQ-010 SHALL have port i_clr, input, 1: synchronous flush of pipeline, accumulators, counter.
REQ-011 SHALL have port o, output, LANES*WIDTH: signed batch-mean gradient per lane, same packing as i_x.
REQ-012 SHALL have port o_valid, output, 1: one-cycle pulse, o holds a new batch result.
REQ-013 SHALL have port o_cnt, output, BATCH_LOG2: products accumulated in the current batch.

Function
REQ-014 SHALL accept a sample on every rising edge with i_valid=1 and i_clr=0; no backpressure, back-to-back samples every cycle.
REQ-015 SHALL form per lane the 2*WIDTH signed product i_d*i_x[n], select bits [WIDTH+FRAC-1:FRAC] (truncation toward minus infinity), register it in stage 1 with a stage-1 valid bit.
REQ-016 SHALL in stage 2, when stage-1 valid=1, add each lane product to its WIDTH-bit accumulator and increment o_cnt.
REQ-017 SHALL, when stage 2 adds the 2^BATCH_LOG2-th product, load o with (accumulator+product) arithmetic-shifted right by BATCH_LOG2, pulse o_valid for one cycle, zero all accumulators and o_cnt in the same edge.
REQ-018 SHALL give latency of 2 edges from acceptance of the last batch sample to o_valid=1.
REQ-019 SHALL hold o stable between o_valid pulses; o_valid=0 otherwise.
REQ-020 SHALL accept a sample arriving in the same cycle the batch completes as the first sample of the next batch, with no loss.
REQ-021 SHALL on i_clr=1 zero accumulators, o_cnt, stage-1 valid; drop any sample presented that cycle (i_clr wins over i_valid); o and o_valid=0 unaffected except o_valid forced 0.
REQ-022 SHALL wrap o_cnt modulo 2^BATCH_LOG2, reaching 0 only via batch completion, clear or reset.

Reset
REQ-023 SHALL on rst=0, asynchronously, set o=0, o_valid=0, o_cnt=0, all accumulators=0, stage-1 products=0, stage-1 valid=0.
REQ-024 SHALL discard any partial batch and in-flight product on reset mid-operation; first accepted sample after rst=1 starts a fresh batch.

Configuration
REQ-025 SHALL, with macro WGHT_ACC_SAT_EN defined, saturate product selection and accumulator sum to [-2^(WIDTH-1), 2^(WIDTH-1)-1] on overflow.
REQ-026 SHALL, without WGHT_ACC_SAT_EN, wrap both product selection and accumulation modulo 2^WIDTH (two's complement), no extra logic.

Verification (defaults, 1.0 = 0x01000000)
REQ-027 SHALL cover: 8 back-to-back samples d=1.0, all x=0.5 -> o_valid one cycle, 2 edges after 8th sample, every lane o=0x00800000, o_cnt=0.
REQ-028 SHALL cover: 8 samples d=2.0, lane x = 1.0,-1.0,0.25,0 with idle gaps -> o lanes 0x02000000, 0xFE000000, 0x00800000, 0x00000000.
REQ-029 SHALL cover: 5 samples, i_clr together with 6th sample, then 8 samples d=x=1.0 -> no o_valid after clr until 8 new samples; o lanes=0x01000000.
REQ-030 SHALL cover: 16 consecutive samples d=x=1.0 -> two o_valid pulses exactly 8 cycles apart, both o=0x01000000 per lane.
REQ-031 SHALL cover: d=x=0x7FFFFFFF for 8 samples -> with WGHT_ACC_SAT_EN o lanes=0x0FFFFFFF; without, o equals wrapped arithmetic model.
REQ-032 SHALL cover: rst=0 asserted mid-batch after 3 samples -> all outputs 0 immediately, then 8 samples d=x=1.0 give o=0x01000000 with no early o_valid.
